// File: rtl/uart_rx_frame.sv
// 8N1 oversampled UART frame receiver writing bytes into a paged block-RAM slot.
// Optional inter-byte idle timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_frame #(
  parameter logic [4:0]  BYTES   = 5'd4,
  parameter int unsigned OVS     = 16,
  parameter logic [15:0] TIMEOUT = 16'd320
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       en,
  input  logic [5:0] cycle,
  output logic [8:0] addr,
  output logic [7:0] wdata,
  output logic       we,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = $clog2(OVS);
  localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [4:0]    byte_q, byte_d;
  logic [8:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          need_high_q, need_high_d;
`ifdef UART_RX_TIMEOUT_EN
  logic [15:0]   idle_q, idle_d;
`else
  logic          timeout_unused;
  assign timeout_unused = ^TIMEOUT;
`endif

  assign rxs = sync_q[1];

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    need_high_d = need_high_q;
`ifdef UART_RX_TIMEOUT_EN
    idle_d      = idle_q;
`endif
    if (!en) begin
      // Disarm has priority over every state, including a coincident stop sample.
      state_d     = IDLE;
      tick_d      = '0;
      bit_d       = '0;
      byte_d      = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      need_high_d = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      idle_d      = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rxs) need_high_d = 1'b0;
          if (!done_q && !need_high_q && !rxs) begin
            state_d = START;
            tick_d  = '0;
`ifdef UART_RX_TIMEOUT_EN
            idle_d  = '0;
          end else if (byte_q != 5'd0 && !done_q) begin
            idle_d = idle_q + 16'd1;
            if (idle_d == TIMEOUT) begin
              err_d  = 1'b1;
              byte_d = '0;
              idle_d = '0;
            end
`endif
          end
        end
        START: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == FULL) begin
            tick_d  = '0;
            shreg_d = {rxs, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end
        end
        STOP: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == FULL) begin
            tick_d  = '0;
            state_d = IDLE;
            if (rxs) begin
              we_d    = 1'b1;
              wdata_d = shreg_q;
              addr_d  = {4'b0, byte_q} + {1'b0, cycle, 2'b00};
              byte_d  = byte_q + 5'd1;
              if (byte_d == BYTES) done_d = 1'b1;
            end else begin
              err_d       = 1'b1;
              need_high_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      byte_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      need_high_q <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      sync_q      <= {sync_q[0], rx};
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      done_q      <= done_d;
      err_q       <= err_d;
      need_high_q <= need_high_d;
`ifdef UART_RX_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign we    = we_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial frame receiver for the RS485 link, the receiving end of the frame transmitter. It deserialises 8N1 UART bytes from an oversampled line, writes each byte into a block-RAM slot at `byte_index + (cycle << 2)`, and raises `done` when `BYTES` bytes have been stored. It is armed and released by `en`, with the same request/complete level handshake used by the transmit side.

## Interface
- `BYTES`, 5'd4: bytes per frame, 1..31.
- `OVS`, 16: clk cycles per bit, even, 4..64.
- `TIMEOUT`, 16'd320: inter-byte idle limit in clk cycles; used only with `UART_RX_TIMEOUT_EN`.

Ports:
- `clk`  in  1: sampling clock, `OVS`× baud.
- `reset`  in  1: asynchronous, active-low.
- `rx`  in  1: serial line, asynchronous, idle high.
- `en`  in  1: arm. Low holds the FSM in IDLE and clears `done`, `err` and the byte count.
- `cycle`  in  6: memory page select.
- `addr`  out  9: write address.
- `wdata`  out  8: received byte.
- `we`  out  1: one-cycle write strobe.
- `done`  out  1: frame complete, held until `en` falls.
- `err`  out  1: sticky error (framing or timeout), held until `en` falls.

## Operation
- `rx` passes through a 2-FF synchroniser that resets to 1. All logic below uses the synchronised value `rxs`.
- States:
  - IDLE: if `en`, not `done` and `rxs==0`, go to START with the bit counter at 0.
  - START: wait `OVS/2` cycles, then sample. If `rxs==1` it was a glitch; return to IDLE with nothing written. Otherwise go to DATA.
  - DATA: sample every `OVS` cycles. 8 bits, LSB first, shifted into `shreg`.
  - STOP: sample after `OVS` cycles.
    - `rxs==1`: next cycle `we=1`, `wdata=shreg`, `addr=byte_cnt+(cycle<<2)`, then `byte_cnt++`.
    - `rxs==0`: set `err`, no write, `byte_cnt` unchanged. Return to IDLE, where a new start requires `rxs` to be seen high first.
  - After STOP, return to IDLE. If `byte_cnt==BYTES` after the increment, set `done`.
- While `done=1`, further start bits are ignored and there are no writes.
- `en` low in any state forces IDLE on the next clock: counters 0, `done=0`, `err=0`, `we=0`. Any partial byte is discarded.
- Address arithmetic: `{4'b0,byte_cnt}+{1'b0,cycle,2'b00}`, truncated to 9 bits. For `BYTES>4`, pages overlap; this is intentional and matches the transmitter.
- `cycle` is sampled in the same cycle that `addr` is formed.

## Timing
- Reset values: `addr=0`, `wdata=0`, `we=0`, `done=0`, `err=0`, FSM IDLE, `rxs=1`.
- Let t0 be the first clk with `rxs==0` in IDLE (2–3 clks after the `rx` falling edge).
- Start sample: t0+`OVS/2`.
- Data bit i (0..7) sample: t0+`OVS/2`+(i+1)·`OVS`.
- Stop sample: t0+`OVS/2`+9·`OVS`.
- `we`, `addr` and `wdata` are valid together at stop sample +1, for exactly one cycle. `addr`/`wdata` then hold until the next write.
- `done` rises in the same cycle as the last `we`.
- A back-to-back start bit is accepted from stop sample +1 onward. This tolerates up to `OVS/2` cycles of early start.
- `err` rises at stop sample +1.
- Simultaneous `en` fall and stop sample: `en` wins. No write, no `done`.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - A 16-bit idle counter runs in IDLE while `0<byte_cnt<BYTES` and `done=0`.
  - It clears on every start detection.
  - When it reaches `TIMEOUT`: set `err` and clear `byte_cnt` to 0. The next byte is written at `cycle<<2`.
- `UART_RX_TIMEOUT_EN` not defined: no counter. A partial frame waits indefinitely until `en` falls.

## Test plan
- Correct frame: `OVS=16`, `cycle=3`, send 0xA5,0x3C,0x00,0xFF back-to-back.
  - Writes (12,0xA5),(13,0x3C),(14,0x00),(15,0xFF), each `we` exactly 1 clk.
  - `done` rises with the 4th `we`; `err=0`.
- Glitch rejection: 4-clk low pulse on idle `rx` → no `we`, FSM back in IDLE. A following valid 0x55 is received correctly at addr 0 with `cycle=0`.
- Framing error: 0x81 with stop bit held low → `err=1`, no write. Line returns high, then 0x81 is sent correctly → written at byte index 0 and `err` stays 1.
- Handshake: after `done`, send a fifth byte → no `we`. Drop `en` → `done=0`, `err=0` next clk. Re-raise `en` and send a frame → writes restart at index 0.
- Reset mid-operation:
  - Assert `reset` during data bit 4 → all outputs at reset values immediately.
  - Release `reset` → next frame received correctly.
  - Drop `en` mid-byte → no write from the partial byte.
- With `UART_RX_TIMEOUT_EN`, `TIMEOUT=320`: send 2 bytes, then idle 321 clks → `err=1`. The next byte is written at `cycle<<2`. Without the macro, the same stimulus gives `err=0` and the next byte goes to index 2.
